// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with an auto-scan (walking-one) sequencer, dwell timer and wrap pulse.
// Optional macro DEC_SCAN_BIDIR_EN adds a dir input for downward scanning.
//
// state  | meaning
// IDLE   | disabled: y=0, valid=0, idx holds its last value
// DECODE | y is the one-hot decode of a, registered
// SCAN   | walking one, each index held for dwell+1 cycles
module onehot_decoder_seq #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
`ifdef DEC_SCAN_BIDIR_EN
  input  logic               dir,
`endif
  input  logic [SEL_W-1:0]   a,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] y,
  output logic [SEL_W-1:0]   idx,
  output logic               valid,
  output logic               wrap
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  localparam logic [SEL_W:0]   NUM_OUT_W = (SEL_W + 1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);

  logic [1:0]         state_q, state_d;
  logic [NUM_OUT-1:0] y_q, y_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic               a_ok;
  logic               scan_down;
  logic [SEL_W-1:0]   load_idx;
  logic [SEL_W-1:0]   next_idx;

  function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = NUM_OUT'(1) << i;
  endfunction

`ifdef DEC_SCAN_BIDIR_EN
  assign scan_down = dir;
`else
  assign scan_down = 1'b0;
`endif

  assign a_ok     = ({1'b0, a} < NUM_OUT_W);
  assign load_idx = a_ok ? a : '0;

  // Explicit wrap compares keep idx inside 0..NUM_OUT-1 for non-power-of-two NUM_OUT.
  always_comb begin
    next_idx = '0;
    if (scan_down) begin
      next_idx = (idx_q == '0) ? LAST_IDX : idx_q - SEL_W'(1);
    end else begin
      next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;

    if (!en) begin
      state_d = IDLE;
      y_d     = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (!mode) begin
      state_d = DECODE;
      cnt_d   = '0;
      if (a_ok) begin
        y_d     = onehot(a);
        idx_d   = a;
        valid_d = 1'b1;
      end else begin
        y_d     = '0;
        valid_d = 1'b0;
      end
    end else begin
      state_d = SCAN;
      if (state_q != SCAN || load) begin
        idx_d   = load_idx;
        y_d     = onehot(load_idx);
        valid_d = 1'b1;
        cnt_d   = '0;
      end else if (cnt_q >= dwell) begin
        // dwell is compared live so a lowered value takes effect immediately
        idx_d   = next_idx;
        y_d     = onehot(next_idx);
        valid_d = 1'b1;
        cnt_d   = '0;
        wrap_d  = scan_down ? (idx_q == '0) : (idx_q == LAST_IDX);
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule
